// File: rtl/sump_pkg.sv
// Shared definitions for the sample transmit path: group geometry, FSM
// encoding and the helper that builds the pending-byte mask at send time.
package sump_pkg;

  localparam int GROUP_COUNT = 4;
  localparam int BYTE_W      = 8;
  localparam int LANE_W      = 2;
  localparam int WORD_W      = GROUP_COUNT * BYTE_W;

  localparam logic [1:0] ST_IDLE_ENC = 2'd0;
  localparam logic [1:0] ST_SEND_ENC = 2'd1;
  localparam logic [1:0] ST_DONE_ENC = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = ST_IDLE_ENC,
    ST_SEND = ST_SEND_ENC,
    ST_DONE = ST_DONE_ENC
  } tx_state_e;

  // Low popcount(en) bits set: packed data occupies the bottom lanes.
  function automatic logic [GROUP_COUNT-1:0] thermo_mask(input logic [GROUP_COUNT-1:0] en);
    int n;
    logic [GROUP_COUNT-1:0] m;
    n = 0;
    for (int i = 0; i < GROUP_COUNT; i++) n += int'(en[i]);
    m = '0;
    for (int i = 0; i < GROUP_COUNT; i++) m[i] = (i < n);
    return m;
  endfunction

  // Native lanes send exactly the enabled groups; packed data uses the
  // thermometer of the enabled-group count.
  function automatic logic [GROUP_COUNT-1:0] pending_mask(input logic [GROUP_COUNT-1:0] en,
                                                          input bit aligned);
    return aligned ? thermo_mask(en) : en;
  endfunction

endpackage

// File: rtl/group_pick.sv
// Lowest-set-bit selector over the pending-byte mask: lane index of the next
// byte to send and the one-hot vector that retires it.
module group_pick
  import sump_pkg::*;
(
  input  logic [GROUP_COUNT-1:0] mask_i,
  output logic [LANE_W-1:0]      lane_o,
  output logic [GROUP_COUNT-1:0] clear_o
);

  // Scan from the top down so the lowest set bit wins.
  always_comb begin
    lane_o  = '0;
    clear_o = '0;
    for (int i = GROUP_COUNT - 1; i >= 0; i--) begin
      if (mask_i[i]) begin
        lane_o     = LANE_W'(i);
        clear_o    = '0;
        clear_o[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sample_tx.sv
// Serializes one 32-bit sample word per send pulse into a valid/ready byte
// stream, skipping disabled groups, and holds busy until the word is done.
//
//  state | meaning
//  IDLE  | waiting for send; busy low
//  SEND  | presenting pending bytes, lowest lane first
//  DONE  | last byte accepted (or none to send); busy drops next edge
module sample_tx
  import sump_pkg::*;
#(
  parameter bit ALIGNED = 1'b1
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   send_i,
  input  logic [WORD_W-1:0]      wrdata_i,
  input  logic [GROUP_COUNT-1:0] disabled_groups_i,
  output logic                   busy_o,
  output logic                   overrun_o,
  output logic [BYTE_W-1:0]      tx_data_o,
  output logic                   tx_valid_o,
  input  logic                   tx_ready_i
);

  tx_state_e              state_q, state_d;
  logic [WORD_W-1:0]      data_q, data_d;
  logic [GROUP_COUNT-1:0] mask_q, mask_d;
  logic                   overrun_q, overrun_d;

  logic [LANE_W-1:0]      lane;
  logic [GROUP_COUNT-1:0] clear;
  logic [GROUP_COUNT-1:0] new_mask;

  group_pick u_pick (
    .mask_i  (mask_q),
    .lane_o  (lane),
    .clear_o (clear)
  );

  assign new_mask = pending_mask(~disabled_groups_i, ALIGNED);

  // State, latched word/mask and sticky overrun.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      data_q    <= '0;
      mask_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      mask_q    <= mask_d;
      overrun_q <= overrun_d;
    end
  end

  // Next-state: latch on send, retire one byte per handshake.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    mask_d    = mask_q;
    overrun_d = overrun_q;
    case (state_q)
      ST_IDLE: begin
        if (send_i) begin
          data_d  = wrdata_i;
          mask_d  = new_mask;
          state_d = (new_mask != '0) ? ST_SEND : ST_DONE;
        end
      end
      ST_SEND: begin
        if (send_i) overrun_d = 1'b1;
        if (tx_ready_i) begin
          mask_d = mask_q & ~clear;
          if ((mask_q & ~clear) == '0) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (send_i) overrun_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs come straight from registered state, so they hold across stalls.
  assign busy_o     = (state_q != ST_IDLE);
  assign tx_valid_o = (state_q == ST_SEND);
  assign tx_data_o  = tx_valid_o ? data_q[BYTE_W*int'(lane) +: BYTE_W] : '0;
  assign overrun_o  = overrun_q;

endmodule

// File: tb/tb_sample_tx.sv
// Bench for sample_tx: two instances (packed and native lanes) share stimulus
// and are checked against a byte-list model of the transfer rules.
module tb_sample_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        send;
  logic [31:0] wrdata;
  logic [3:0]  dis;
  logic        tx_ready;

  logic [1:0]      vld, bsy, ovr;
  logic [1:0][7:0] dat;

  int checks   = 0;
  int failures = 0;
  bit ovr_exp  = 1'b0;

  always #5 clk = ~clk;

  sample_tx #(.ALIGNED(1'b1)) dut_a (
    .clock_i(clk), .reset_i(rst), .send_i(send), .wrdata_i(wrdata),
    .disabled_groups_i(dis), .busy_o(bsy[0]), .overrun_o(ovr[0]),
    .tx_data_o(dat[0]), .tx_valid_o(vld[0]), .tx_ready_i(tx_ready)
  );

  sample_tx #(.ALIGNED(1'b0)) dut_n (
    .clock_i(clk), .reset_i(rst), .send_i(send), .wrdata_i(wrdata),
    .disabled_groups_i(dis), .busy_o(bsy[1]), .overrun_o(ovr[1]),
    .tx_data_o(dat[1]), .tx_valid_o(vld[1]), .tx_ready_i(tx_ready)
  );

  // Model: number of bytes a word produces, and the i-th byte in send order.
  function automatic int exp_count(input logic [3:0] d);
    int n = 0;
    for (int k = 0; k < 4; k++) if (!d[k]) n++;
    return n;
  endfunction

  function automatic logic [7:0] exp_byte(input logic [31:0] w, input logic [3:0] d,
                                          input bit aligned, input int i);
    int k = 0;
    if (aligned) return w[8*i +: 8];
    for (int lane = 0; lane < 4; lane++) begin
      if (!d[lane]) begin
        if (k == i) return w[8*lane +: 8];
        k++;
      end
    end
    return 8'h00;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // tx_ready held high: exact cycle-by-cycle timing for both instances.
  task automatic word_fast(input logic [31:0] w, input logic [3:0] d);
    int n[2];
    tx_ready = 1'b1;
    @(negedge clk);
    send = 1'b1; wrdata = w; dis = d;
    @(negedge clk);
    send = 1'b0; dis = 4'($urandom);
    wrdata = $urandom;
    n[0] = exp_count(d); n[1] = n[0];
    for (int c = 0; c < 7; c++) begin
      for (int u = 0; u < 2; u++) begin
        if (c < n[u]) begin
          chk($sformatf("fast_valid%0d_c%0d", u, c), 32'(vld[u]), 32'd1);
          chk($sformatf("fast_data%0d_c%0d", u, c), 32'(dat[u]), 32'(exp_byte(w, d, u == 0, c)));
          chk($sformatf("fast_busy%0d_c%0d", u, c), 32'(bsy[u]), 32'd1);
        end else if (c == n[u]) begin
          chk($sformatf("fast_valid%0d_c%0d", u, c), 32'(vld[u]), 32'd0);
          chk($sformatf("fast_busy%0d_c%0d", u, c), 32'(bsy[u]), 32'd1);
        end else begin
          chk($sformatf("fast_valid%0d_c%0d", u, c), 32'(vld[u]), 32'd0);
          chk($sformatf("fast_busy%0d_c%0d", u, c), 32'(bsy[u]), 32'd0);
        end
      end
      @(negedge clk);
    end
    for (int u = 0; u < 2; u++)
      chk($sformatf("fast_overrun%0d", u), 32'(ovr[u]), 32'(ovr_exp));
  endtask

  // Throttled transfer: ready from a pattern or random; bytes scored at
  // handshakes, stalled outputs must hold. An extra send can be injected.
  task automatic word_stall(input logic [31:0] w, input logic [3:0] d,
                            input logic [31:0] rpat, input bit rnd, input int ovr_cyc);
    int  n, idx[2];
    bit  stall[2];
    logic [7:0] pdat[2];
    bit  r, done;
    n = exp_count(d);
    idx[0] = 0; idx[1] = 0; stall[0] = 0; stall[1] = 0;
    done = 1'b0;
    @(negedge clk);
    send = 1'b1; wrdata = w; dis = d;
    @(negedge clk);
    send = 1'b0; dis = 4'($urandom);
    for (int c = 0; c < 300 && !done; c++) begin
      if (c == ovr_cyc) begin
        send = 1'b1; wrdata = ~w; ovr_exp = 1'b1;
      end else begin
        send = 1'b0;
      end
      r = rnd ? 1'($urandom) : ((c < 32) ? rpat[c] : 1'b1);
      tx_ready = r;
      for (int u = 0; u < 2; u++) begin
        if (stall[u]) begin
          chk($sformatf("hold_valid%0d", u), 32'(vld[u]), 32'd1);
          chk($sformatf("hold_data%0d", u), 32'(dat[u]), 32'(pdat[u]));
        end
        if (vld[u] && r) begin
          if (idx[u] < n) chk($sformatf("byte%0d_%0d", u, idx[u]), 32'(dat[u]),
                              32'(exp_byte(w, d, u == 0, idx[u])));
          else chk($sformatf("extra_byte%0d", u), 32'(vld[u]), 32'd0);
          idx[u]++;
        end
        stall[u] = vld[u] && !r;
        pdat[u]  = dat[u];
      end
      if (c > 0 && bsy == 2'b00) done = 1'b1;
      else @(negedge clk);
    end
    send = 1'b0;
    chk("stall_timeout", 32'(done), 32'd1);
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("stall_count%0d", u), 32'(idx[u]), 32'(n));
      chk($sformatf("stall_overrun%0d", u), 32'(ovr[u]), 32'(ovr_exp));
    end
  endtask

  initial begin
    rst = 1'b1; send = 1'b0; wrdata = '0; dis = '0; tx_ready = 1'b0;
    #12;
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("rst_valid%0d", u), 32'(vld[u]), 32'd0);
      chk($sformatf("rst_busy%0d", u), 32'(bsy[u]), 32'd0);
      chk($sformatf("rst_overrun%0d", u), 32'(ovr[u]), 32'd0);
      chk($sformatf("rst_data%0d", u), 32'(dat[u]), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    word_fast(32'hA1B2C3D4, 4'b0000);
    word_fast(32'h11223344, 4'b0101);
    word_fast(32'hDEADBEEF, 4'b1111);
    word_fast(32'h55667788, 4'b1000);

    word_stall($urandom, 4'b0000, ~32'h0000_003E, 1'b0, -1);
    for (int i = 0; i < 20; i++)
      word_stall($urandom, 4'($urandom), 32'hFFFF_FFFF, 1'b1, -1);

    word_stall(32'hCAFEF00D, 4'b0000, ~32'h0000_000C, 1'b0, 1);
    word_fast($urandom, 4'($urandom));
    word_stall($urandom, 4'($urandom), 32'hFFFF_FFFF, 1'b1, -1);

    // Reset after the first byte has been accepted.
    tx_ready = 1'b1;
    @(negedge clk);
    send = 1'b1; wrdata = 32'h0BADF00D; dis = 4'b0000;
    @(negedge clk);
    send = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    ovr_exp = 1'b0;
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("midrst_valid%0d", u), 32'(vld[u]), 32'd0);
      chk($sformatf("midrst_busy%0d", u), 32'(bsy[u]), 32'd0);
      chk($sformatf("midrst_overrun%0d", u), 32'(ovr[u]), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    word_fast(32'h89ABCDEF, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
